// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Consumers: mem_arb_pick, mem_arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        WRITE
    } state_e;

    typedef enum logic {
        PORT_IF,
        PORT_DM
    } port_e;

    localparam logic [1:0] BANK_INSTR = 2'b00;
    localparam logic [1:0] BANK_D1    = 2'b01;
    localparam logic [1:0] BANK_D2    = 2'b10;
    localparam logic [1:0] BANK_D3    = 2'b11;

    function automatic logic [1:0] bank_of(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:ADDR_W-2];
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the fetch and data ports.
// Build option: MEM_ARB_RR_EN selects round-robin ties; otherwise data always beats fetch.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic  i_if_req,
    input  logic  i_dm_req,
`ifdef MEM_ARB_RR_EN
    input  port_e i_last,
`endif
    output logic  o_valid,
    output port_e o_winner
);

    always_comb begin
        o_valid  = i_if_req | i_dm_req;
        o_winner = PORT_DM;
        if (i_if_req && !i_dm_req) begin
            o_winner = PORT_IF;
        end
`ifdef MEM_ARB_RR_EN
        // On a tie the port granted least recently wins.
        if (i_if_req && i_dm_req) begin
            o_winner = (i_last == PORT_DM) ? PORT_IF : PORT_DM;
        end
`endif
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: serializes fetch and data requests onto one shared memory bus.
// Build option: MEM_ARB_RR_EN selects round-robin tie-breaking instead of data-first priority.
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_valid,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_we,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_gnt,
    output logic              o_dm_valid,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic [ADDR_W-1:0] o_mem_address_bus,
    inout  wire  [DATA_W-1:0] io_mem_data_bus,
    output logic              o_mem_write_mode
);

    state_e            r_state;
    state_e            w_state_d;
    port_e             r_port;
    port_e             w_winner;
    logic              w_req_any;
    logic              w_grant;
    logic              w_store;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_write_mode;
    logic              r_if_valid;
    logic              r_dm_valid;
`ifdef MEM_ARB_RR_EN
    port_e             r_last;
`endif

    mem_arb_pick u_pick (
        .i_if_req (i_if_req),
        .i_dm_req (i_dm_req),
`ifdef MEM_ARB_RR_EN
        .i_last   (r_last),
`endif
        .o_valid  (w_req_any),
        .o_winner (w_winner)
    );

    // Reset blocks any grant in the cycle it is asserted.
    assign w_grant  = (r_state == IDLE) && w_req_any && !i_reset;
    assign o_if_gnt = w_grant && (w_winner == PORT_IF);
    assign o_dm_gnt = w_grant && (w_winner == PORT_DM);
    assign w_store  = o_dm_gnt && i_dm_we;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_d = w_store ? WRITE : READ;
            READ:    w_state_d = CAPTURE;
            CAPTURE: w_state_d = IDLE;
            WRITE:   w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_port       <= PORT_IF;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_dm_rdata   <= '0;
            r_write_mode <= 1'b0;
            r_if_valid   <= 1'b0;
            r_dm_valid   <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last       <= PORT_IF;
`endif
        end else begin
            r_state      <= w_state_d;
            r_write_mode <= (w_state_d == WRITE);
            r_if_valid   <= 1'b0;
            r_dm_valid   <= 1'b0;
            if (w_grant) begin
                r_port  <= w_winner;
                r_addr  <= (w_winner == PORT_DM) ? i_dm_addr : i_if_addr;
                r_wdata <= i_dm_wdata;
`ifdef MEM_ARB_RR_EN
                r_last  <= w_winner;
`endif
            end
            if (r_state == CAPTURE) begin
                if (r_port == PORT_DM) begin
                    r_dm_rdata <= io_mem_data_bus;
                    r_dm_valid <= 1'b1;
                end else begin
                    r_if_rdata <= io_mem_data_bus;
                    r_if_valid <= 1'b1;
                end
            end
            if (r_state == WRITE) begin
                r_dm_valid <= 1'b1;
            end
        end
    end

    // Drive the bus only while the strobe is up so memory and arbiter never contend.
    assign io_mem_data_bus   = r_write_mode ? r_wdata : {DATA_W{1'bz}};
    assign o_mem_address_bus = r_addr;
    assign o_mem_write_mode  = r_write_mode;
    assign o_if_valid        = r_if_valid;
    assign o_if_rdata        = r_if_rdata;
    assign o_dm_valid        = r_dm_valid;
    assign o_dm_rdata        = r_dm_rdata;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared 4 KB memory, which has a 12-bit byte address, a 16-bit bidirectional data bus and a single write_mode strobe. It accepts instruction-fetch reads and data load/store requests and serializes them onto the one memory bus. It also drives the bus direction so that memory and arbiter never contend. It sits between the CPU front end / load-store unit and the memory block.

## Interface
- ADDR_W, 12, byte address width; bits [11:10] select the bank, [9:1] the word, [0] is ignored.
- DATA_W, 16, data word width.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch byte address.
- if_gnt  out  1  one-cycle pulse when the fetch request is accepted.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  fetched word, held until the next fetch completes.
- dm_req  in  1  data request; held with dm_we, dm_addr and dm_wdata stable until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  one-cycle pulse when the data request is accepted.
- dm_valid  out  1  one-cycle pulse: load data is valid, or the store has completed.
- dm_rdata  out  DATA_W  load word, held until the next load completes.
- mem_address_bus  out  ADDR_W  memory address, registered.
- mem_data_bus  inout  DATA_W  driven with the latched store data only while mem_write_mode=1, otherwise high-Z.
- mem_write_mode  out  1  memory write strobe, registered.

## Operation
- States:
  - IDLE: bus idle.
  - READ: address presented; the memory samples it at the end of this cycle.
  - CAPTURE: memory output is valid on mem_data_bus; the arbiter registers it at the end of this cycle.
  - WRITE: mem_write_mode=1 with data driven; the memory writes at the end of this cycle.
- In IDLE with at least one request pending:
  - the winner's gnt is asserted combinationally in that cycle;
  - its address, we, wdata and port ID are latched at the edge;
  - next state is WRITE for a store, otherwise READ.
- Transitions: READ -> CAPTURE -> IDLE. WRITE -> IDLE.
- Fetches are always reads. There is no write path from the fetch port.
- On the CAPTURE exit edge, the word goes to the owning port's rdata and that port's valid pulses in the next cycle.
- On the WRITE exit edge, dm_valid is set for one cycle.
- Grants are only issued in IDLE. Requests arriving in other states wait; they are neither dropped nor queued beyond the held req.
- Arbitration (both requests pending in IDLE): see Configuration.
- mem_address_bus holds its last value while in IDLE. mem_write_mode is 0 in every state except WRITE.
- Addresses pass through unmodified. Misaligned (odd) addresses access the containing word. Bank 0 stores are allowed.

## Timing
- Reset values:
  - state IDLE;
  - mem_write_mode 0, so mem_data_bus is high-Z;
  - mem_address_bus 0;
  - if_valid, dm_valid 0;
  - if_rdata, dm_rdata 0;
  - round-robin pointer set to fetch-last (data wins the first tie).
- Read: gnt in cycle 0 -> READ in cycle 1 -> CAPTURE in cycle 2 -> valid in cycle 3, which is also IDLE. A new grant is possible in cycle 3. Throughput is one read per 3 cycles.
- Write: gnt in cycle 0 -> WRITE in cycle 1 -> dm_valid in cycle 2, which is also IDLE. Throughput is one write per 2 cycles.
- The gnt and valid of successive transactions may coincide in the same cycle (on different ports, or on the same port).
- Reset asserted mid-transaction:
  - state returns to IDLE at that edge and no valid pulse is produced;
  - a memory write already in WRITE still takes effect at that edge, because the strobe is registered;
  - a read in flight is discarded.
- Simultaneous req and reset: no grant is issued.

## Configuration
- MEM_ARB_RR_EN defined: round-robin. On a tie, the port not granted most recently wins. The pointer updates on every grant.
- MEM_ARB_RR_EN undefined: fixed priority, data port always over fetch. The pointer logic is absent.

## Structure
- Package mem_arb_pkg holds:
  - ADDR_W and DATA_W defaults;
  - the state enum (IDLE, READ, CAPTURE, WRITE);
  - the port ID enum (PORT_IF, PORT_DM);
  - bank constants BANK_INSTR=2'b00, BANK_D1..BANK_D3.
- One sub-module, mem_arb_pick: given the two reqs and the last-granted port, it returns the winner. Both arbitration modes live there under the macro.

## Test plan
- Memory preloaded with 16'hABCD at word 510 of bank 3: dm load to 12'hFFC -> dm_gnt cycle 0, dm_valid and dm_rdata=16'hABCD in cycle 3; mem_write_mode stays 0 throughout.
- dm store 16'h1234 to 12'h402, then dm load from 12'h402 -> dm_valid on the store 2 cycles after its grant; the load returns 16'h1234.
- if_req and dm_req held together over 4 transactions:
  - with MEM_ARB_RR_EN, grants go DM, IF, DM, IF;
  - without it, only DM is granted while dm_req is held, and IF is granted after dm_req drops.
- Fetch from 12'h000 with a store to 12'h000 issued in the same cycle -> the store is granted first (tie rule), and the fetch then returns the stored value.
- Reset asserted during CAPTURE -> no valid pulse, state IDLE next cycle, and mem_data_bus is high-Z from the arbiter side at all times except WRITE cycles.
- Back-to-back fetches with if_req held -> if_gnt every 3 cycles, and if_valid coincides with the next if_gnt.
